crc_field_sequencer: RTL and testbench

Sequences CRC-16 CCITT checking of MFM sector fields for the FluxRipper read path. It sits between the address-mark detector/byte assembler and the sector buffer. On each sync it presets the CRC engine with the three A1 sync bytes, classifies the mark byte, and counts ID or data field bytes including the two CRC bytes. It then reports a registered pass/fail result and the decoded ID record.

---
 rtl/fdc_pkg.sv | 39 +++
 rtl/crc16_ccitt.sv | 26 ++
 rtl/crc_field_sequencer.sv | 158 +++++++++++++++
 tb/tb_crc_field_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared floppy-controller definitions: address-mark bytes, CRC constants,
// sequencer state encoding and the field_type code reported to the buffer.
package fdc_pkg;

  localparam logic [7:0]  MARK_ID       = 8'hFE;
  localparam logic [7:0]  MARK_DATA     = 8'hFB;
  localparam logic [7:0]  MARK_DDAM     = 8'hF8;
  localparam logic [7:0]  SYNC_A1       = 8'hA1;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_PRESET_A1 = 16'hCDB4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_MARK,
    ST_ID_FIELD,
    ST_DATA_FIELD,
    ST_CHECK
  } seq_state_t;

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_ID   = 2'd1,
    FT_DATA = 2'd2,
    FT_DDAM = 2'd3
  } field_type_t;

  // MSB-first CRC-16/CCITT update over one byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// Byte-wise registered CRC-16/CCITT engine; init presets 0xFFFF, each
// data_valid byte updates crc_out on the following cycle.
module crc16_ccitt
  import fdc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      crc_q <= CRC_INIT;
    end else if (data_valid) begin
      crc_q <= crc16_byte(crc_q, data_in);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/crc_field_sequencer.sv
// Sequences CRC checking of MFM ID/data fields: preset with A1 x3 after sync,
// classify the mark, count the field, then report a registered pass/fail.
module crc_field_sequencer
  import fdc_pkg::*;
#(
  parameter int MAX_N     = 6,
  parameter int DEFAULT_N = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_found,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       busy,
  output logic [1:0] field_type,
  output logic       result_valid,
  output logic       crc_ok,
  output logic       mark_err,
  output logic       resync,
  output logic [7:0] id_c,
  output logic [7:0] id_h,
  output logic [7:0] id_r,
  output logic [7:0] id_n,
  output logic       data_en
);

  seq_state_t  state_q;
  field_type_t cur_ft_q, ft_q;
  logic [1:0]  pre_cnt_q;
  logic [14:0] cnt_q;
  logic        skid_vld_q, sync_pend_q;
  logic [7:0]  skid_q;
  logic        rv_q, ok_q, merr_q, resync_q;
  logic [7:0]  sh_c_q, sh_h_q, sh_r_q, sh_n_q;
  logic [7:0]  id_c_q, id_h_q, id_r_q, id_n_q, n_q;

  logic        in_field, sync_go, abort, crc_init, crc_en, mark_vld, fld_take;
  logic [7:0]  mark_byte, crc_din, n_eff;
  logic [14:0] data_len;
  logic [15:0] crc_val;

  assign in_field  = (state_q == ST_ID_FIELD) || (state_q == ST_DATA_FIELD);
  assign sync_go   = (state_q == ST_IDLE) && (sync_found || sync_pend_q);
  assign abort     = sync_found && ((state_q == ST_MARK) || in_field);
  // A sync during preload simply restarts the preset; nothing was reported yet.
  assign crc_init  = sync_go || abort || (sync_found && (state_q == ST_PRELOAD));
  assign mark_byte = skid_vld_q ? skid_q : byte_data;
  assign mark_vld  = (state_q == ST_MARK) && !sync_found && (skid_vld_q || byte_valid);
  assign fld_take  = in_field && byte_valid && !sync_found;
  assign crc_en    = (state_q == ST_PRELOAD) || mark_vld || fld_take;
  assign crc_din   = (state_q == ST_PRELOAD) ? SYNC_A1 : ((state_q == ST_MARK) ? mark_byte : byte_data);
  assign n_eff     = (n_q > 8'(MAX_N)) ? 8'(MAX_N) : n_q;
  assign data_len  = 15'((32'd128 << n_eff) + 32'd2);
  assign data_en   = fld_take && (state_q == ST_DATA_FIELD) && (cnt_q > 15'd2);

  crc16_ccitt u_crc (
    .clk        (clk),
    .reset      (1'b0),
    .init       (crc_init),
    .data_valid (crc_en),
    .data_in    (crc_din),
    .crc_out    (crc_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;     cur_ft_q <= FT_NONE;  ft_q <= FT_NONE;
      pre_cnt_q <= 2'd0;      cnt_q <= 15'd0;
      skid_vld_q <= 1'b0;     skid_q <= 8'h00;      sync_pend_q <= 1'b0;
      rv_q <= 1'b0;           ok_q <= 1'b0;         merr_q <= 1'b0;   resync_q <= 1'b0;
      sh_c_q <= 8'h00;        sh_h_q <= 8'h00;      sh_r_q <= 8'h00;  sh_n_q <= 8'h00;
      id_c_q <= 8'h00;        id_h_q <= 8'h00;      id_r_q <= 8'h00;  id_n_q <= 8'h00;
      n_q <= 8'(DEFAULT_N);
    end else begin
      rv_q        <= 1'b0;
      merr_q      <= 1'b0;
      resync_q    <= 1'b0;
      sync_pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          skid_vld_q <= 1'b0;
          if (sync_go) begin
            state_q   <= ST_PRELOAD;
            pre_cnt_q <= 2'd0;
          end
        end
        ST_PRELOAD: begin
          if (sync_found) begin
            pre_cnt_q  <= 2'd0;
            skid_vld_q <= 1'b0;
          end else begin
            if (byte_valid) begin
              skid_q     <= byte_data;
              skid_vld_q <= 1'b1;
            end
            pre_cnt_q <= pre_cnt_q + 2'd1;
            if (pre_cnt_q == 2'd2) state_q <= ST_MARK;
          end
        end
        ST_MARK, ST_ID_FIELD, ST_DATA_FIELD: begin
          if (abort) begin
            resync_q   <= 1'b1;
            state_q    <= ST_PRELOAD;
            pre_cnt_q  <= 2'd0;
            skid_vld_q <= 1'b0;
          end else if (mark_vld) begin
            skid_vld_q <= 1'b0;
            case (mark_byte)
              MARK_ID:   begin cur_ft_q <= FT_ID;   cnt_q <= 15'd6;   state_q <= ST_ID_FIELD;   end
              MARK_DATA: begin cur_ft_q <= FT_DATA; cnt_q <= data_len; state_q <= ST_DATA_FIELD; end
              MARK_DDAM: begin cur_ft_q <= FT_DDAM; cnt_q <= data_len; state_q <= ST_DATA_FIELD; end
              default:   begin merr_q <= 1'b1;      state_q <= ST_IDLE; end
            endcase
          end else if (fld_take) begin
            cnt_q <= cnt_q - 15'd1;
            if (state_q == ST_ID_FIELD) begin
              case (cnt_q)
                15'd6:   sh_c_q <= byte_data;
                15'd5:   sh_h_q <= byte_data;
                15'd4:   sh_r_q <= byte_data;
                15'd3:   sh_n_q <= byte_data;
                default: ;
              endcase
            end
            if (cnt_q == 15'd1) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          rv_q        <= 1'b1;
          ok_q        <= (crc_val == 16'h0000);
          ft_q        <= cur_ft_q;
          sync_pend_q <= sync_found;
          if ((cur_ft_q == FT_ID) && (crc_val == 16'h0000)) begin
            id_c_q <= sh_c_q;
            id_h_q <= sh_h_q;
            id_r_q <= sh_r_q;
            id_n_q <= sh_n_q;
            n_q    <= sh_n_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign field_type   = ft_q;
  assign result_valid = rv_q;
  assign crc_ok       = ok_q;
  assign mark_err     = merr_q;
  assign resync       = resync_q;
  assign id_c         = id_c_q;
  assign id_h         = id_h_q;
  assign id_r         = id_r_q;
  assign id_n         = id_n_q;

endmodule

// File: tb/tb_crc_field_sequencer.sv
// Randomized field stream against a bit-serial CRC / field-level reference model.
module tb_crc_field_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, sync_found, byte_valid;
  logic [7:0] byte_data;
  logic       busy, result_valid, crc_ok, mark_err, resync, data_en;
  logic [1:0] field_type;
  logic [7:0] id_c, id_h, id_r, id_n;

  always #5 clk = ~clk;

  crc_field_sequencer #(.MAX_N(6), .DEFAULT_N(2)) dut (
    .clk(clk), .reset_n(reset_n), .sync_found(sync_found), .byte_valid(byte_valid),
    .byte_data(byte_data), .busy(busy), .field_type(field_type), .result_valid(result_valid),
    .crc_ok(crc_ok), .mark_err(mark_err), .resync(resync), .id_c(id_c), .id_h(id_h),
    .id_r(id_r), .id_n(id_n), .data_en(data_en)
  );

  int total_n = 0, bad_n = 0;
  int rv_n = 0, me_n = 0, rs_n = 0, de_n = 0;
  logic       last_ok;
  logic [1:0] last_ft;
  logic [7:0] fq[$];
  logic [7:0] m_id[4];
  int         m_n = 2;
  logic       m_ok = 1'b0;
  logic [1:0] m_ft = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    if (obs !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial LFSR over A1 A1 A1, the mark and the queued field bytes.
  function automatic logic [15:0] model_crc(input logic [7:0] mark);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < 4 + fq.size(); i++) begin
      b = (i < 3) ? 8'hA1 : ((i == 3) ? mark : fq[i-4]);
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[k];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic add_crc(input logic [7:0] mark);
    logic [15:0] c;
    c = model_crc(mark);
    fq.push_back(c[15:8]);
    fq.push_back(c[7:0]);
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] d);
    sync_found = s; byte_valid = v; byte_data = d;
    @(negedge clk);
    if (data_en) de_n++;
    chk("de_qual", data_en & ~byte_valid, 0);
    @(posedge clk);
    #1;
    if (result_valid) begin rv_n++; last_ok = crc_ok; last_ft = field_type; end
    if (mark_err) me_n++;
    if (resync) rs_n++;
    sync_found = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_field(input logic [7:0] mark, input bit pre, input bit chain);
    int rv0, me0, de0, off_min, moff, noff, plen;
    bit is_id, is_data, exp_rv, exp_ok;
    rv0 = rv_n; me0 = me_n; de0 = de_n;
    off_min = pre ? 3 : 2;
    moff    = off_min + $urandom_range(0, 3);
    noff    = (moff + 2 > off_min + 4) ? moff + 2 : off_min + 4;
    is_id   = (mark == 8'hFE);
    is_data = (mark == 8'hFB) || (mark == 8'hF8);
    exp_rv  = is_id || is_data;
    exp_ok  = (model_crc(mark) == 16'h0000);
    plen    = is_data ? fq.size() - 2 : 0;
    if (!pre) step(1'b1, 1'b0, 8'h00);
    repeat (moff - 1) idle();
    step(1'b0, 1'b1, mark);
    for (int i = 0; i < fq.size(); i++) begin
      if (i == 0) repeat (noff - moff - 1) idle();
      else repeat ($urandom_range(1, 2)) idle();
      step(1'b0, 1'b1, fq[i]);
    end
    step(chain, 1'b0, 8'h00);
    chk("rv_edge", result_valid, exp_rv);
    if (!chain) repeat (3) idle();
    if (exp_rv) begin
      m_ft = is_id ? 2'd1 : ((mark == 8'hFB) ? 2'd2 : 2'd3);
      m_ok = exp_ok;
      if (is_id && exp_ok) begin
        for (int k = 0; k < 4; k++) m_id[k] = fq[k];
        m_n = int'(fq[3]);
      end
    end
    chk("rv_cnt", rv_n - rv0, exp_rv);
    chk("merr_cnt", me_n - me0, !exp_rv);
    chk("de_cnt", de_n - de0, plen);
    if (exp_rv) begin
      chk("crc_ok", last_ok, m_ok);
      chk("ft_at_rv", last_ft, m_ft);
    end
    chk("field_type", field_type, m_ft);
    chk("id_c", id_c, m_id[0]);
    chk("id_h", id_h, m_id[1]);
    chk("id_r", id_r, m_id[2]);
    chk("id_n", id_n, m_id[3]);
    if (!chain) chk("busy_idle", busy, 0);
    fq.delete();
  endtask

  task automatic start_partial(input int n);
    step(1'b1, 1'b0, 8'h00);
    idle();
    step(1'b0, 1'b1, 8'hFB);
    repeat (3) idle();
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      idle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_ok"}, crc_ok, 0);
    chk({tag, "_merr"}, mark_err, 0);
    chk({tag, "_resync"}, resync, 0);
    chk({tag, "_de"}, data_en, 0);
    chk({tag, "_ft"}, field_type, 0);
    chk({tag, "_idc"}, id_c, 0);
    chk({tag, "_idh"}, id_h, 0);
    chk({tag, "_idr"}, id_r, 0);
    chk({tag, "_idn"}, id_n, 0);
  endtask

  initial begin
    logic [7:0] mk, msk;
    int rs0, rv0, kind, len;
    bit pre, chain;
    for (int k = 0; k < 4; k++) m_id[k] = 8'h00;
    reset_n = 1'b0; sync_found = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Good ID, then the same ID with a corrupted CRC byte.
    fq = '{8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F};
    do_field(8'hFE, 1'b0, 1'b0);
    fq = '{8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6E};
    do_field(8'hFE, 1'b0, 1'b0);

    // 512-byte data field, then N=7 clamps to 8192 payload bytes.
    repeat (512) fq.push_back(8'hE5);
    add_crc(8'hFB);
    do_field(8'hFB, 1'b0, 1'b0);
    fq = '{8'h05, 8'h01, 8'h03, 8'h07};
    add_crc(8'hFE);
    do_field(8'hFE, 1'b0, 1'b0);
    repeat (8192) fq.push_back(8'($urandom_range(0, 255)));
    add_crc(8'hFB);
    do_field(8'hFB, 1'b0, 1'b0);

    // Bad mark byte.
    do_field(8'h55, 1'b0, 1'b0);

    // Sync in the middle of a data field, followed by a good ID.
    rs0 = rs_n; rv0 = rv_n;
    start_partial(100);
    fq = '{8'h10, 8'h00, 8'h04, 8'h02};
    add_crc(8'hFE);
    do_field(8'hFE, 1'b0, 1'b0);
    chk("resync_cnt", rs_n - rs0, 1);
    chk("rv_total", rv_n - rv0, 1);

    // Asynchronous reset in the middle of a data field.
    start_partial(50);
    #2;
    byte_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) m_id[k] = 8'h00;
    m_n = 2; m_ft = 2'd0; m_ok = 1'b0;
    fq = '{8'h22, 8'h01, 8'h09, 8'h01};
    add_crc(8'hFE);
    do_field(8'hFE, 1'b0, 1'b0);

    // Random mix of fields, including syncs landing in the CHECK cycle.
    pre = 1'b0;
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        mk = 8'hFE;
        repeat (3) fq.push_back(8'($urandom_range(0, 255)));
        fq.push_back(8'($urandom_range(0, 2)));
        add_crc(mk);
      end else if (kind == 2) begin
        mk  = ($urandom_range(0, 1) == 1) ? 8'hFB : 8'hF8;
        len = 128 << ((m_n > 6) ? 6 : m_n);
        repeat (len) fq.push_back(8'($urandom_range(0, 255)));
        add_crc(mk);
      end else begin
        do mk = 8'($urandom_range(0, 255)); while (mk == 8'hFE || mk == 8'hFB || mk == 8'hF8);
      end
      if (kind != 3 && $urandom_range(0, 3) == 0) begin
        msk = 8'h01 << $urandom_range(0, 7);
        len = $urandom_range(0, fq.size() - 1);
        fq[len] = fq[len] ^ msk;
      end
      chain = (kind != 3) && (it != 15) && ($urandom_range(0, 2) == 0);
      do_field(mk, pre, chain);
      pre = chain;
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
